// File: rtl/fp_div_32_seq.sv
// fp_div_32_seq: sequential IEEE-754 single-precision divider, quotient = num1 / num2.
// Latency: start sampled on an edge; done 28 edges later (26 DIV + NORM + DONE), 1 edge for zero operands.
// Backpressure: none; start is ignored unless IDLE, inputs captured only on an accepted start.
//
// Ports:
//    clk, rst          rising-edge clock, asynchronous active-high reset
//    start             request, sampled only in IDLE
//    num1, num2        dividend / divisor, captured on accepted start
//    busy              high while DIV or NORM
//    done              one-cycle pulse, quotient valid
//    quotient          result, held until the next completed operation
module fp_div_32_seq #(
   parameter bit ROUND_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient
);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_sign;
   logic [7:0]  r_e1;
   logic [7:0]  r_e2;
   logic [23:0] r_div;    // {1, m2}; constant for the whole operation
   logic [24:0] r_rem;    // partial remainder, always < 2*r_div
   logic [25:0] r_q;      // quotient bits, MSB first; r_q[25] is the integer bit
   logic [4:0]  r_cnt;
   logic [31:0] r_quot;

   // operand classification (exponent field 0 is treated as zero)
   logic        w_z1;
   logic        w_z2;
   logic        w_special;
   logic        w_sign_in;
   logic [31:0] w_special_q;

   assign w_z1      = (num1[30:23] == 8'h00);
   assign w_z2      = (num2[30:23] == 8'h00);
   assign w_special = w_z1 | w_z2;
   assign w_sign_in = num1[31] ^ num2[31];

   always_comb begin
      w_special_q = {w_sign_in, 31'h0};
      if (w_z1 && w_z2)
         w_special_q = 32'h7FC0_0000;
      else if (w_z2)
         w_special_q = {w_sign_in, 8'hFF, 23'h0};
   end

   // one restoring step; when no subtraction happens r_rem < r_div < 2^24, so 24 bits suffice
   logic        w_ge;
   logic [23:0] w_sub;

   assign w_ge  = (r_rem >= {1'b0, r_div});
   assign w_sub = w_ge ? 24'(r_rem - {1'b0, r_div}) : r_rem[23:0];

   // normalisation and rounding
   logic [23:0] w_sig;
   logic        w_rnd;
   logic [7:0]  w_exp_base;
   logic [24:0] w_sig_r;
   logic [7:0]  w_exp;
   logic [22:0] w_mant;

   assign w_sig      = r_q[25] ? r_q[25:2] : r_q[24:1];
   assign w_rnd      = r_q[25] ? r_q[1]    : r_q[0];
   assign w_exp_base = r_e1 - r_e2 + (r_q[25] ? 8'd127 : 8'd126);
   assign w_sig_r    = {1'b0, w_sig} + {24'd0, (ROUND_EN ? w_rnd : 1'b0)};
   assign w_exp      = w_exp_base + {7'd0, w_sig_r[24]};
   // w_sig has its hidden bit set; losing it after rounding means the carry rippled out
   assign w_mant     = w_sig_r[23] ? w_sig_r[22:0] : 23'd0;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = w_special ? S_DONE : S_DIV;
         S_DIV:  if (r_cnt == 5'd25) w_next = S_NORM;
         S_NORM: w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      busy     = (r_state == S_DIV) || (r_state == S_NORM);
      done     = (r_state == S_DONE);
      quotient = r_quot;
   end

   // datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign <= 1'b0;
         r_e1   <= 8'h0;
         r_e2   <= 8'h0;
         r_div  <= 24'h0;
         r_rem  <= 25'h0;
         r_q    <= 26'h0;
         r_cnt  <= 5'h0;
         r_quot <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sign <= w_sign_in;
                  r_e1   <= num1[30:23];
                  r_e2   <= num2[30:23];
                  r_div  <= {1'b1, num2[22:0]};
                  r_rem  <= {2'b01, num1[22:0]};
                  r_q    <= 26'h0;
                  r_cnt  <= 5'h0;
                  if (w_special)
                     r_quot <= w_special_q;
               end
            end
            S_DIV: begin
               r_rem <= {w_sub, 1'b0};
               r_q   <= {r_q[24:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            S_NORM: r_quot <= {r_sign, w_exp, w_mant};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_32_seq.sv
// tb_fp_div_32_seq: directed checks of the sequential FP divider.
// Edge numbering: edge 0 is the edge after which start is driven high; the DUT samples it at edge 1.
// A second instance with rounding disabled shares the inputs.
module tb_fp_div_32_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] num1;
   logic [31:0] num2;
   logic        busy,   busy_t;
   logic        done,   done_t;
   logic [31:0] quotient, quotient_t;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp_div_32_seq #(.ROUND_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
      .busy(busy), .done(done), .quotient(quotient)
   );

   fp_div_32_seq #(.ROUND_EN(1'b0)) dut_t (
      .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
      .busy(busy_t), .done(done_t), .quotient(quotient_t)
   );

   // Drive a start pulse: high after edge 0, low after edge 1. Returns just after edge 1.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      num1 = a; num2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Current sample is edge index 1. Returns the edge index at which done is seen
   // (-1 on timeout) and the number of pre-done samples with busy low.
   task automatic wait_done(output int k, output int gaps);
      k = 1; gaps = 0;
      while (done !== 1'b1 && k < 60) begin
         if (busy !== 1'b1) gaps++;
         @(posedge clk); #1;
         k++;
      end
      if (done !== 1'b1) k = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; num1 = 32'h0; num2 = 32'h0;
      #12;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_vec++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_quot got %h want 00000000", quotient); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", busy, done); end
   endtask

   task automatic test_basic;
      int k, g;
      issue(32'h40C0_0000, 32'h4000_0000);
      wait_done(k, g);
      n_vec++; if (k !== 28) begin n_err++; $display("FAIL lat_6_2 got %0d want 28", k); end
      n_vec++; if (g !== 0) begin n_err++; $display("FAIL busy_6_2 low cycles got %0d want 0", g); end
      n_vec++; if (quotient !== 32'h4040_0000) begin n_err++; $display("FAIL quot_6_2 got %h want 40400000", quotient); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done got %b want 0", busy); end
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b want 0", done); end
      n_vec++; if (quotient !== 32'h4040_0000) begin n_err++; $display("FAIL quot_hold got %h want 40400000", quotient); end
   endtask

   task automatic test_round;
      int k, g;
      issue(32'h3F80_0000, 32'h4040_0000);
      wait_done(k, g);
      n_vec++; if (k !== 28) begin n_err++; $display("FAIL lat_1_3 got %0d want 28", k); end
      n_vec++; if (quotient !== 32'h3EAA_AAAB) begin n_err++; $display("FAIL quot_1_3_round got %h want 3eaaaaab", quotient); end
      n_vec++; if (done_t !== 1'b1) begin n_err++; $display("FAIL done_trunc got %b want 1", done_t); end
      n_vec++; if (quotient_t !== 32'h3EAA_AAAA) begin n_err++; $display("FAIL quot_1_3_trunc got %h want 3eaaaaaa", quotient_t); end
   endtask

   task automatic test_signs_hold;
      int k, g;
      @(posedge clk); #1;
      num1 = 32'hC0F0_0000; num2 = 32'h4020_0000; start = 1'b1;
      @(posedge clk); #1;
      // start stays high; these operands must only be picked up after done
      num1 = 32'h4110_0000; num2 = 32'h4040_0000;
      wait_done(k, g);
      n_vec++; if (k !== 28) begin n_err++; $display("FAIL lat_hold got %0d want 28", k); end
      n_vec++; if (quotient !== 32'hC040_0000) begin n_err++; $display("FAIL quot_neg got %h want c0400000", quotient); end
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_gap done=%b busy=%b want 0/0", done, busy); end
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL second_accept busy got %b want 1", busy); end
      start = 1'b0;
      wait_done(k, g);
      n_vec++; if (k !== 28) begin n_err++; $display("FAIL lat_second got %0d want 28", k); end
      n_vec++; if (quotient !== 32'h4040_0000) begin n_err++; $display("FAIL quot_9_3_held got %h want 40400000", quotient); end
   endtask

   task automatic test_specials;
      logic [31:0] ta [3];
      logic [31:0] tb [3];
      logic [31:0] te [3];
      int k, g;
      ta[0] = 32'h3F80_0000; tb[0] = 32'h0000_0000; te[0] = 32'h7F80_0000;
      ta[1] = 32'h8000_0000; tb[1] = 32'h4000_0000; te[1] = 32'h8000_0000;
      ta[2] = 32'h0000_0000; tb[2] = 32'h0000_0000; te[2] = 32'h7FC0_0000;
      for (int i = 0; i < 3; i++) begin
         issue(ta[i], tb[i]);
         wait_done(k, g);
         n_vec++; if (k !== 1) begin n_err++; $display("FAIL lat_special%0d got %0d want 1", i, k); end
         n_vec++; if (quotient !== te[i]) begin n_err++; $display("FAIL quot_special%0d got %h want %h", i, quotient, te[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_op;
      int k, g, seen;
      issue(32'h40C0_0000, 32'h4000_0000);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", done); end
      n_vec++; if (quotient !== 32'h0) begin n_err++; $display("FAIL midrst_quot got %h want 00000000", quotient); end
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (35) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_stray_done got %0d want 0", seen); end
      issue(32'h4110_0000, 32'h4040_0000);
      wait_done(k, g);
      n_vec++; if (k !== 28) begin n_err++; $display("FAIL lat_9_3 got %0d want 28", k); end
      n_vec++; if (quotient !== 32'h4040_0000) begin n_err++; $display("FAIL quot_9_3 got %h want 40400000", quotient); end
   endtask

   task automatic test_busy_immunity;
      int k, g;
      issue(32'h40C0_0000, 32'h4000_0000);
      repeat (4) @(posedge clk);
      #1;
      num1 = 32'h3F80_0000; num2 = 32'h0000_0000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // now at edge 6, so done is 22 samples away
      wait_done(k, g);
      n_vec++; if (k !== 23) begin n_err++; $display("FAIL lat_immune got %0d want 23", k); end
      n_vec++; if (quotient !== 32'h4040_0000) begin n_err++; $display("FAIL quot_immune got %h want 40400000", quotient); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round();
      test_signs_hold();
      test_specials();
      test_reset_mid_op();
      test_busy_immunity();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
